// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX fetch path.
package dlx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DELIVER = 2'd2,
      WAIT_EN = 2'd3
   } fetch_state_t;

   localparam logic [31:0] DLX_NOP        = 32'h0000_0000;
   localparam logic [31:0] DLX_WORD_BYTES = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dlx_fetch_if.sv
// Instruction memory read channel: single outstanding word read, req held until ack.
interface dlx_fetch_if;

   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;

   modport master (
      output i_req,
      output i_addr,
      input  i_ack,
      input  i_rdata
   );

   modport slave (
      input  i_req,
      input  i_addr,
      output i_ack,
      output i_rdata
   );

endinterface

// File: rtl/dlx_fetch.sv
// DLX instruction fetch: owns the PC, reads instruction memory and strobes each word to decode.
module dlx_fetch
   import dlx_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_en,
   input  logic        pc_load,
   input  logic [31:0] pc_new,
   dlx_fetch_if.master imem,
   output logic [31:0] instr,
   output logic        ID,
   output logic [31:0] pc_cur,
   output logic [31:0] pc_next,
   output logic        busy
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         squash_q, squash_d;
   logic         started_q, started_d;
   logic         req_q, req_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc_cur_q, pc_cur_d;
   logic [31:0]  pc_next_q, pc_next_d;
   logic         id_q, id_d;

   logic [31:0]  load_pc;
   logic [31:0]  entry_pc;

   assign load_pc  = word_align(pc_new);
   // A redirect in the same cycle as FETCH entry steers the new request.
   assign entry_pc = pc_load ? load_pc : pc_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      squash_d  = squash_q;
      started_d = started_q;
      req_d     = req_q;
      addr_d    = addr_q;
      instr_d   = instr_q;
      pc_cur_d  = pc_cur_q;
      pc_next_d = pc_next_q;
      id_d      = 1'b0;

      if (pc_load) begin
         pc_d = load_pc;
      end

      unique case (state_q)
         IDLE: begin
            // First cycle out of reset only arms; a squash refetch passes straight through.
            if (started_q) begin
               state_d = FETCH;
               req_d   = 1'b1;
               addr_d  = entry_pc;
            end else begin
               started_d = 1'b1;
            end
         end
         FETCH: begin
            if (imem.i_ack) begin
               req_d = 1'b0;
               if (squash_q || pc_load) begin
                  squash_d = 1'b0;
                  state_d  = IDLE;
               end else begin
                  instr_d   = imem.i_rdata;
                  pc_cur_d  = addr_q;
                  pc_next_d = addr_q + DLX_WORD_BYTES;
                  pc_d      = addr_q + DLX_WORD_BYTES;
                  id_d      = 1'b1;
                  state_d   = DELIVER;
               end
            end else if (pc_load) begin
               squash_d = 1'b1;
            end
         end
         DELIVER: begin
            state_d = WAIT_EN;
         end
         WAIT_EN: begin
            if (fetch_en) begin
               state_d = FETCH;
               req_d   = 1'b1;
               addr_d  = entry_pc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         squash_q  <= 1'b0;
         started_q <= 1'b0;
         req_q     <= 1'b0;
         addr_q    <= 32'h0;
         instr_q   <= DLX_NOP;
         pc_cur_q  <= 32'h0;
         pc_next_q <= 32'h0;
         id_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         squash_q  <= squash_d;
         started_q <= started_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         instr_q   <= instr_d;
         pc_cur_q  <= pc_cur_d;
         pc_next_q <= pc_next_d;
         id_q      <= id_d;
      end
   end

   assign imem.i_req  = req_q;
   assign imem.i_addr = addr_q;
   assign instr       = instr_q;
   assign ID          = id_q;
   assign pc_cur      = pc_cur_q;
   assign pc_next     = pc_next_q;
   assign busy        = (state_q == FETCH);

endmodule
